// File: rtl/cnn_conv_ctrl_if.sv
// Pixel-in / result-out stream bundle for cnn_conv_ctrl.
// The slave modport is the controller side; the master modport is the source/sink side.
interface cnn_conv_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
);
   logic                         pix_valid_i;
   logic                         pix_ready_o;
   logic signed [DATA_WIDTH-1:0] pix_data_i;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic signed [ACC_WIDTH-1:0]  out_data_o;
   logic                         out_last_o;

   modport slave (
      input  pix_valid_i, pix_data_i, out_ready_i,
      output pix_ready_o, out_valid_o, out_data_o, out_last_o
   );

   modport master (
      output pix_valid_i, pix_data_i, out_ready_i,
      input  pix_ready_o, out_valid_o, out_data_o, out_last_o
   );
endinterface

// File: rtl/cnn_conv_ctrl.sv
// 3x3 valid-mode convolution sequencer: line buffers, sliding window, local weights, result stream.
// Optional build macro CNN_CONV_CTRL_RELU_EN clamps negative sums to zero before the output register.
module cnn_conv_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int IMG_W      = 16,
   parameter int IMG_H      = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   output logic                         busy_o,
   output logic                         done_o,
   input  logic                         wgt_we_i,
   input  logic [3:0]                   wgt_addr_i,
   input  logic signed [DATA_WIDTH-1:0] wgt_data_i,
   cnn_conv_ctrl_if.slave               strm
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                col_q, col_d;
   logic [RW-1:0]                row_q, row_d;
   logic signed [DATA_WIDTH-1:0] wgt_q [9];
   logic signed [DATA_WIDTH-1:0] wgt_d [9];
   logic signed [DATA_WIDTH-1:0] win_q [9];
   logic signed [DATA_WIDTH-1:0] win_d [9];
   logic signed [DATA_WIDTH-1:0] lb1_q [IMG_W];
   logic signed [DATA_WIDTH-1:0] lb2_q [IMG_W];
   logic                         out_valid_q, out_valid_d;
   logic                         out_last_q, out_last_d;
   logic signed [ACC_WIDTH-1:0]  out_data_q, out_data_d;
   logic signed [ACC_WIDTH-1:0]  sum, res;
   logic signed [PW-1:0]         prod;
   logic                         pix_ready, accept, out_hs, col_end, row_end, has_result;

   always_comb begin
      pix_ready  = (state_q == S_RUN) && (!out_valid_q || strm.out_ready_i);
      accept     = pix_ready && strm.pix_valid_i;
      out_hs     = out_valid_q && strm.out_ready_i;
      col_end    = (col_q == CW'(IMG_W - 1));
      row_end    = (row_q == RW'(IMG_H - 1));
      has_result = (row_q >= RW'(2)) && (col_q >= CW'(2));
   end

   // Line buffer entry [col] holds rows r-1 (lb1) and r-2 (lb2); read before overwrite.
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int unsigned i = 0; i < 9; i += 3) begin
            win_d[i]   = win_q[i+1];
            win_d[i+1] = win_q[i+2];
         end
         win_d[2] = lb2_q[col_q];
         win_d[5] = lb1_q[col_q];
         win_d[8] = strm.pix_data_i;
      end
   end

   // The sum is taken from the post-shift window so the result registers on the accepting edge.
   always_comb begin
      sum  = '0;
      prod = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         prod = PW'(win_d[i]) * PW'(wgt_q[i]);
         sum  = sum + ACC_WIDTH'(prod);
      end
`ifdef CNN_CONV_CTRL_RELU_EN
      res = sum[ACC_WIDTH-1] ? '0 : sum;
`else
      res = sum;
`endif
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      wgt_d       = wgt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (wgt_we_i && (wgt_addr_i <= 4'd8)) wgt_d[wgt_addr_i] = wgt_data_i;
            if (start_i) begin
               state_d = S_RUN;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (col_end) begin
                  col_d = '0;
                  if (row_end) begin
                     row_d   = '0;
                     state_d = S_LAST;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         S_LAST:  if (out_hs) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (out_hs) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      if (accept && has_result) begin
         out_valid_d = 1'b1;
         out_data_d  = res;
         out_last_d  = row_end && col_end;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         wgt_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         wgt_q       <= wgt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk_i) begin
      win_q <= win_d;
      if (accept) begin
         lb1_q[col_q] <= strm.pix_data_i;
         lb2_q[col_q] <= lb1_q[col_q];
      end
   end

   assign busy_o           = (state_q == S_RUN) || (state_q == S_LAST);
   assign done_o           = (state_q == S_DONE);
   assign strm.pix_ready_o = pix_ready;
   assign strm.out_valid_o = out_valid_q;
   assign strm.out_data_o  = out_data_q;
   assign strm.out_last_o  = out_last_q;
endmodule

// File: tb/tb_cnn_conv_ctrl.sv
// Directed + randomized bench for cnn_conv_ctrl on a 4x4 image, checked against a plain 2D-convolution model.
module tb_cnn_conv_ctrl;
   localparam int DW = 8;
   localparam int AW = 32;
   localparam int W  = 4;
   localparam int H  = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start, wgt_we;
   logic [3:0]           wgt_addr;
   logic signed [DW-1:0] wgt_data;
   logic                 busy, done;

   int total = 0;
   int bad   = 0;

   int       wmod [9];
   int       img  [W*H];
   longint   exp_q [$];
   bit       last_q [$];

   always #5 clk = ~clk;

   cnn_conv_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

   cnn_conv_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMG_W(W), .IMG_H(H)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .busy_o     (busy),
      .done_o     (done),
      .wgt_we_i   (wgt_we),
      .wgt_addr_i (wgt_addr),
      .wgt_data_i (wgt_data),
      .strm       (bus)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Valid-mode convolution over the whole image, in raster order of the window's bottom-right pixel.
   task automatic build_expected();
      longint s;
      exp_q.delete();
      last_q.delete();
      for (int r = 2; r < H; r++)
         for (int c = 2; c < W; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += longint'(img[(r-2+i)*W + (c-2+j)]) * longint'(wmod[i*3+j]);
`ifdef CNN_CONV_CTRL_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_q.push_back(s);
            last_q.push_back((r == H-1) && (c == W-1));
         end
   endtask

   task automatic set_w_all(input int v);
      for (int i = 0; i < 9; i++) wmod[i] = v;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < W*H; i++) img[i] = i;
   endtask

   task automatic load_weights();
      for (int i = 0; i < 9; i++) begin
         @(posedge clk) #1;
         wgt_we = 1'b1; wgt_addr = 4'(i); wgt_data = DW'(wmod[i]);
      end
      // Out-of-range addresses must not alias onto real weights.
      for (int a = 9; a < 16; a += 3) begin
         @(posedge clk) #1;
         wgt_we = 1'b1; wgt_addr = 4'(a); wgt_data = 8'sd55;
      end
      @(posedge clk) #1;
      wgt_we = 1'b0;
   endtask

   // rmode: 0 ready always high, 1 random ready, 2 ready low for cycles 9..13.
   task automatic run_frame(input int rmode, input bit rand_valid, input bit inject, input int abort_at);
      int  sent, got, nexp, cyc;
      bit  done_seen, held, aborted;
      logic signed [AW-1:0] hold_val;
      build_expected();
      nexp = exp_q.size();
      sent = 0; got = 0; cyc = 0; done_seen = 0; held = 0; aborted = 0; hold_val = '0;
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      chk("busy_in_run", busy, 1);
      while (!done_seen && cyc < 3000) begin
         bus.pix_valid_i = (sent < W*H) && (!rand_valid || $urandom_range(0, 3) != 0);
         bus.pix_data_i  = (sent < W*H) ? DW'(img[sent]) : '0;
         case (rmode)
            0:       bus.out_ready_i = 1'b1;
            1:       bus.out_ready_i = ($urandom_range(0, 2) != 0);
            default: bus.out_ready_i = !(cyc >= 9 && cyc <= 13);
         endcase
         if (inject && sent == 3) begin
            wgt_we = 1'b1; wgt_addr = 4'd4; wgt_data = 8'sd7;
            start  = 1'b1;
         end
         @(negedge clk);
         if (held) begin
            chk("hold_valid", bus.out_valid_o, 1);
            chk("hold_data", bus.out_data_o, hold_val);
            held = 0;
         end
         if (bus.out_valid_o && !bus.out_ready_i) begin
            chk("stall_pix_ready", bus.pix_ready_o, 0);
            held = 1;
            hold_val = bus.out_data_o;
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("extra_result", got + 1, nexp);
            end else begin
               chk("result_data", bus.out_data_o, exp_q.pop_front());
               chk("result_last", bus.out_last_o, last_q.pop_front());
            end
            got++;
         end
         if (bus.pix_valid_i && bus.pix_ready_o) sent++;
         if (done) done_seen = 1;
         if (abort_at > 0 && sent == abort_at) begin
            aborted = 1;
            break;
         end
         @(posedge clk) #1;
         wgt_we = 1'b0;
         start  = 1'b0;
         cyc++;
      end
      wgt_we = 1'b0;
      start  = 1'b0;
      if (aborted) begin
         #1 rst_n = 1'b0;
         #1;
         chk("abort_busy", busy, 0);
         chk("abort_done", done, 0);
         chk("abort_out_valid", bus.out_valid_o, 0);
         chk("abort_out_data", bus.out_data_o, 0);
         chk("abort_out_last", bus.out_last_o, 0);
         chk("abort_pix_ready", bus.pix_ready_o, 0);
         bus.pix_valid_i = 1'b0;
         @(posedge clk) #2 rst_n = 1'b1;
         @(negedge clk);
         chk("abort_idle_busy", busy, 0);
      end else begin
         bus.pix_valid_i = 1'b0;
         chk("frame_done_seen", done_seen, 1);
         chk("result_count", got, nexp);
         @(posedge clk) #1;
         @(negedge clk);
         chk("done_single_pulse", done, 0);
         chk("busy_after_done", busy, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; wgt_we = 1'b0; wgt_addr = '0; wgt_data = '0;
      bus.pix_valid_i = 1'b0; bus.pix_data_i = '0; bus.out_ready_i = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_out_data", bus.out_data_o, 0);
      chk("rst_out_last", bus.out_last_o, 0);
      chk("rst_pix_ready", bus.pix_ready_o, 0);
      #22 rst_n = 1'b1;

      // Identity kernel on a ramp: 5,6,9,10.
      set_w_all(0); wmod[4] = 1; set_ramp();
      load_weights();
      run_frame(0, 0, 0, 0);

      // All-ones kernel on a ramp: 45,54,81,90.
      set_w_all(1);
      load_weights();
      run_frame(0, 0, 0, 0);

      // Same again with the result stream stalled around the first result.
      run_frame(2, 0, 0, 0);

      // Signed extremes.
      set_w_all(-128);
      for (int i = 0; i < W*H; i++) img[i] = -128;
      load_weights();
      run_frame(1, 1, 0, 0);

      // Identity frame with a weight write and a start pulse injected mid-run.
      set_w_all(0); wmod[4] = 1; set_ramp();
      load_weights();
      run_frame(1, 1, 1, 0);

      // Random kernels and images under random flow control.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 9; i++) wmod[i] = int'($urandom_range(0, 255)) - 128;
         for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(0, 255)) - 128;
         load_weights();
         run_frame(1, 1, 0, 0);
      end

      // Negative sums: raw or clamped depending on build.
      set_w_all(-1); set_ramp();
      load_weights();
      run_frame(0, 0, 0, 0);

      // Reset mid-frame, then weights are back to zero.
      set_w_all(1); set_ramp();
      load_weights();
      run_frame(1, 0, 0, 11);
      set_w_all(0);
      run_frame(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cnn_conv_ctrl.md
Name: cnn_conv_ctrl

Overview:
Streaming sequencer for the 3x3 convolution datapath. It accepts a raster-order pixel stream, builds the 3x3 sliding window with two internal line buffers, and drives one instance of the team's 3x3 conv unit with a locally stored weight set. It emits valid-mode (no padding) results as a valid/ready stream. It sits between the image DMA/stream source and the result writer in the CNN accelerator.

Parameters:
DATA_WIDTH, 8, signed pixel/weight width
ACC_WIDTH, 32, signed accumulator/result width
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
start_i  in  1  start one frame (honoured only in IDLE)
busy_o  out  1  high in RUN and LAST
done_o  out  1  one-cycle pulse after final result handshake
wgt_we_i  in  1  weight write strobe
wgt_addr_i  in  4  weight index 0..8, row-major, 0 = top-left
wgt_data_i  in  DATA_WIDTH  signed weight value
pix_valid_i  in  1  input pixel valid
pix_ready_o  out  1  input pixel ready
pix_data_i  in  DATA_WIDTH  signed pixel
out_valid_o  out  1  result valid
out_ready_i  in  1  result ready
out_data_o  out  ACC_WIDTH  signed convolution result
out_last_o  out  1  marks the final result of the frame

Behaviour:
- One clock domain, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: all outputs 0; all 9 weights 0; state IDLE; row/col counters 0. Line-buffer contents are not reset and are don't-care.
- Weights:
  - Written only in IDLE when wgt_we_i=1 and wgt_addr_i<=8.
  - Writes in other states, or with addr>8, are ignored.
  - Weights persist across frames.
- FSM states:
  - IDLE: start_i goes to RUN and clears the counters.
  - RUN: accepts pixels. Goes to LAST when the last pixel (row IMG_H-1, col IMG_W-1) is accepted.
  - LAST: waits for the final result handshake, then goes to DONE.
  - DONE: asserts done_o for one cycle, then returns to IDLE.
- pix_ready_o = (state==RUN) && (!out_valid_o || out_ready_i).
- A pixel is accepted when pix_valid_i && pix_ready_o. On acceptance:
  - The pixel shifts into the window.
  - The line buffers advance.
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
- Window ordering:
  - window[0..2] = row r-2, cols c-2..c.
  - window[3..5] = row r-1.
  - window[6..8] = row r.
  - The right column is the newest.
- A pixel accepted at (r,c) with r>=2 and c>=2 produces a result. out_data_o/out_valid_o register on the next clock (latency 1). Acceptances with r<2 or c<2 produce no result.
- Output register:
  - Holds its value while out_valid_o && !out_ready_i.
  - Clears valid on handshake unless a new result loads in the same cycle.
- out_last_o is high together with the result from pixel (IMG_H-1, IMG_W-1).
- Results per frame: (IMG_W-2)*(IMG_H-2).
- Arithmetic: signed products, full-precision sum, sign-extended to ACC_WIDTH. No saturation: ACC_WIDTH>=2*DATA_WIDTH+4 is required.
- start_i outside IDLE is ignored. pix_valid_i outside RUN is ignored (not accepted).
- Reset mid-frame: returns immediately to IDLE with outputs cleared; partial results are discarded.

Optional Feature:
CNN_CONV_CTRL_RELU_EN
- Defined: out_data_o = max(0, sum). A negative sum yields 0, applied before the output register.
- Undefined: the raw signed sum is passed through.
- Latency is identical in both builds.

Test Plan:
- Identity kernel, ramp image: IMG_W=IMG_H=4, weight[4]=1 (others 0), pixels 0..15 raster, ready held 1 -> 4 results 5,6,9,10; out_last_o on 10; done_o pulses once.
- All-ones kernel, same ramp image -> results 45,54,81,90; busy_o falls after done_o.
- Backpressure: all-ones kernel, out_ready_i=0 for 5 cycles around the first result -> pix_ready_o low while stalled; 45 held stable; no loss or duplication; sequence 45,54,81,90.
- Signed extremes: all weights -128, all pixels -128 -> every result 147456.
- Weight write in RUN is ignored; start_i mid-frame is ignored; rst_ni pulsed mid-frame -> outputs 0 and IDLE; weights read back as 0 (identity frame then gives all 0).
- Weights all -1, ramp image -> with CNN_CONV_CTRL_RELU_EN: 0,0,0,0; without: -45,-54,-81,-90.
